// File: rtl/sysid_checker_master.sv
// sysid_checker_master
//   Avalon-MM read master that reads the system-ID slave (word 0 = ID,
//   word 1 = build timestamp) after reset or on a start pulse, and compares
//   both words against values compiled into the hardware.
// Ports
//   clock, reset_n          clock, asynchronous active-low reset
//   start                   pulse to begin a check (dropped while busy)
//   avm_address, avm_read   Avalon-MM read request (address 0 = ID, 1 = TS)
//   avm_waitrequest         slave stall
//   avm_readdata            slave read data
//   busy, done              check in progress / one-cycle end-of-check pulse
//   id_ok, ts_ok, timeout   result flags of the last check
//   id_value, ts_value      last captured ID / timestamp words
module sysid_checker_master #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h65FF_E144,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FIN} state_t;

  localparam bit          NO_LAT  = (READ_LATENCY == 0);
  localparam logic [2:0]  LAT_END = 3'(READ_LATENCY);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic        pending;
  logic [15:0] wait_cnt;
  logic [1:0]  lat_cnt;
  logic        cap_id_q, cap_ts_q;

  logic accept, stall_abort, lat_done, capture_id, capture_ts, launch;

  assign accept      = avm_read && !avm_waitrequest;
  // wait_cnt already holds the stall cycles before this one, so this cycle
  // is stall number TIMEOUT_CYCLES when the count equals TIMEOUT_CYCLES-1.
  assign stall_abort = avm_read && avm_waitrequest && (wait_cnt == TO_LAST);
  assign lat_done    = (({1'b0, lat_cnt} + 3'd1) == LAT_END);
  assign capture_id  = (state == RD_ID  && accept && NO_LAT) || (state == LAT_ID && lat_done);
  assign capture_ts  = (state == RD_TS  && accept && NO_LAT) || (state == LAT_TS && lat_done);
  assign launch      = (state == IDLE) && (start || pending);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (start || pending) state_next = RD_ID;
      RD_ID:  if (accept)           state_next = NO_LAT ? RD_TS : LAT_ID;
              else if (stall_abort) state_next = FIN;
      LAT_ID: if (lat_done)         state_next = RD_TS;
      RD_TS:  if (accept)           state_next = NO_LAT ? FIN : LAT_TS;
              else if (stall_abort) state_next = FIN;
      LAT_TS: if (lat_done)         state_next = FIN;
      FIN:                          state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // Outputs decode straight from state so reset drops avm_read asynchronously.
  always_comb begin
    avm_read    = (state == RD_ID) || (state == RD_TS);
    avm_address = (state == RD_TS);
    busy        = (state == RD_ID) || (state == LAT_ID) ||
                  (state == RD_TS) || (state == LAT_TS);
    done        = (state == FIN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= AUTO_START;
      wait_cnt <= '0;
      lat_cnt  <= '0;
      cap_id_q <= 1'b0;
      cap_ts_q <= 1'b0;
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      // Non-stalled cycles (including accept) clear the count, so every RD
      // entry starts from zero.
      if (avm_read && avm_waitrequest) wait_cnt <= wait_cnt + 16'd1;
      else                             wait_cnt <= '0;

      if ((state == LAT_ID || state == LAT_TS) && !lat_done) lat_cnt <= lat_cnt + 2'd1;
      else                                                   lat_cnt <= '0;

      cap_id_q <= capture_id;
      cap_ts_q <= capture_ts;
      if (capture_id) id_value <= avm_readdata;
      if (capture_ts) ts_value <= avm_readdata;

      if (launch) begin
        pending <= 1'b0;
        timeout <= 1'b0;
        id_ok   <= 1'b0;
        ts_ok   <= 1'b0;
      end else begin
        if (stall_abort) timeout <= 1'b1;
        if (cap_id_q)    id_ok   <= (id_value == EXPECTED_ID);
        if (cap_ts_q)    ts_ok   <= (ts_value == EXPECTED_TS);
      end
    end
  end

endmodule
